pending_encoder8_3: RTL and testbench

//  Sequential 8-to-3 priority encoder; inverse of the clocked 3-to-8 decoder.

---
 rtl/pending_encoder8_3_pkg.sv | 15 +
 rtl/pending_encoder8_3_if.sv | 30 +++
 rtl/pending_encoder8_3_prio_enc8.sv | 39 +++
 rtl/pending_encoder8_3.sv | 84 ++++++++
 tb/tb_pending_encoder8_3.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pending_encoder8_3_pkg.sv
// Shared constants and helpers for the sequential 8-to-3 pending-event encoder.
package pending_encoder_pkg;

    localparam int N = 8;
    localparam int W = 3;

    // Turns an issued code into the one-hot mask of the pending bit it claims.
    function automatic logic [N-1:0] onehot_dec(input logic [W-1:0] code);
        logic [N-1:0] mask;
        mask       = '0;
        mask[code] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/pending_encoder8_3_if.sv
// Request/pending/output-stream bundle of the pending encoder.
interface pending_encoder8_3_if;
    import pending_encoder_pkg::*;

    logic [N-1:0] req;
    logic [W-1:0] out_code;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] pending;
    logic         ovf;

    // The encoder masters the code stream and consumes the request lines.
    modport master (
        input  req,
        input  out_ready,
        output out_code,
        output out_valid,
        output pending,
        output ovf
    );

    modport slave (
        output req,
        output out_ready,
        input  out_code,
        input  out_valid,
        input  pending,
        input  ovf
    );
endinterface

// File: rtl/pending_encoder8_3_prio_enc8.sv
// Combinational 8-way priority search from a start index; direction is descending
// (fixed priority) by default and ascending with wrap when ROUND_ROBIN_EN is defined.
module prio_enc8
    import pending_encoder_pkg::*;
(
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] code,
    output logic         any
);

    logic [W-1:0] w_idx [N];
    logic [N-1:0] w_rot;

    // w_rot[k] is the k-th candidate in search order; index arithmetic wraps mod 8.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
`ifdef ROUND_ROBIN_EN
            assign w_idx[gi] = start + W'(gi);
`else
            assign w_idx[gi] = start - W'(gi);
`endif
            assign w_rot[gi] = vec[w_idx[gi]];
        end
    endgenerate

    always_comb begin
        code = '0;
        any  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                code = w_idx[k];
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pending_encoder8_3.sv
// Sequential 8-to-3 priority encoder: rising request edges become pending events,
// issued one code at a time over valid/ready. ROUND_ROBIN_EN selects rotating priority.
module pending_encoder8_3
    import pending_encoder_pkg::*;
(
    input  logic                  CP,
    input  logic                  CR,
    pending_encoder8_3_if.master  bus
);

    logic [N-1:0] r_req_q;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_out_code;
    logic         r_out_valid;
    logic         r_ovf;

    logic [N-1:0] w_rise;
    logic         w_load;
    logic [W-1:0] w_start;
    logic [W-1:0] w_code;
    logic         w_any;
    logic         w_claim;
    logic [N-1:0] w_claim_mask;
    logic [N-1:0] w_pending_next;
    logic         w_ovf_next;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] r_rr_last;

    assign w_start = r_rr_last + 1'b1;

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            r_rr_last <= W'(N - 1);
        end else if (w_claim) begin
            r_rr_last <= w_code;
        end
    end
`else
    assign w_start = W'(N - 1);
`endif

    prio_enc8 u_prio (
        .vec   (r_pending),
        .start (w_start),
        .code  (w_code),
        .any   (w_any)
    );

    assign w_rise       = bus.req & ~r_req_q;
    assign w_load       = ~r_out_valid | bus.out_ready;
    assign w_claim      = w_load & w_any;
    assign w_claim_mask = w_claim ? onehot_dec(w_code) : '0;

    // A rise on the bit being claimed this cycle re-arms it rather than being lost.
    assign w_pending_next = (r_pending & ~w_claim_mask) | w_rise;
    assign w_ovf_next     = |(w_rise & r_pending & ~w_claim_mask);

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            r_req_q     <= '0;
            r_pending   <= '0;
            r_out_code  <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_req_q   <= bus.req;
            r_pending <= w_pending_next;
            r_ovf     <= w_ovf_next;
            if (w_load) begin
                r_out_valid <= w_any;
                if (w_any) begin
                    r_out_code <= w_code;
                end
            end
        end
    end

    assign bus.out_code  = r_out_code;
    assign bus.out_valid = r_out_valid;
    assign bus.pending   = r_pending;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_pending_encoder8_3.sv
// Scoreboard bench for pending_encoder8_3: expected codes are queued as stimulus is
// applied and popped whenever the encoder hands a code to the consumer.
module tb_pending_encoder8_3;

    logic CP = 1'b0;
    logic CR;

    pending_encoder8_3_if bus ();

    pending_encoder8_3 dut (
        .CP  (CP),
        .CR  (CR),
        .bus (bus)
    );

    always #5 CP = ~CP;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [2:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic push3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        sb_q.push_back(a);
        sb_q.push_back(b);
        sb_q.push_back(c);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 24 && (bus.out_valid || bus.pending != 0); i++) tick();
        check(tag, {23'd0, bus.out_valid, bus.pending}, 32'd0);
    endtask

    // Consumer side: inputs only change just after posedge, so a handshake seen at
    // negedge is exactly the one taken at the following posedge.
    always @(negedge CP) begin
        if (CR && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [2:0] exp_code;
                exp_code = sb_q.pop_front();
                $display("accept code=%0d exp=%0d @%0t", bus.out_code, exp_code, $time);
                check("sb_code", 32'(bus.out_code), 32'(exp_code));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all requests high: everything cleared asynchronously.
        CR = 1'b0;
        bus.req = 8'hFF;
        bus.out_ready = 1'b0;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_code", 32'(bus.out_code), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        tick();
        tick();
        check("rst_hold_pending", 32'(bus.pending), 32'd0);
        CR = 1'b1;
        tick();
        check("t1_pending", 32'(bus.pending), 32'hFF);
        check("t1_valid0", 32'(bus.out_valid), 32'd0);
        tick();
        check("t1_code", 32'(bus.out_code), 32'd7);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 7; k >= 0; k--) sb_q.push_back(3'(k));
        bus.out_ready = 1'b1;
        wait_idle("t1_drain");
        bus.req = 8'h00;
        tick();

        // Fixed priority burst 0010_0101.
        bus.req = 8'b0010_0101;
        push3(3'd5, 3'd2, 3'd0);
        tick();
        check("t2_pending", 32'(bus.pending), 32'h25);
        bus.req = 8'h00;
        tick();
        check("t2_code5", 32'(bus.out_code), 32'd5);
        tick();
        check("t2_code2", 32'(bus.out_code), 32'd2);
        tick();
        check("t2_code0", 32'(bus.out_code), 32'd0);
        check("t2_valid", 32'(bus.out_valid), 32'd1);
        tick();
        check("t2_idle", 32'(bus.out_valid), 32'd0);

        // Backpressure with a new event arriving while code 3 is held.
        bus.out_ready = 1'b0;
        bus.req = 8'h08;
        tick();
        bus.req = 8'h00;
        tick();
        for (int h = 0; h < 5; h++) begin
            if (h == 1) bus.req = 8'h40;
            tick();
            if (h == 1) begin
                check("t3_pend6", 32'(bus.pending[6]), 32'd1);
                bus.req = 8'h00;
            end
            check("t3_hold_code", 32'(bus.out_code), 32'd3);
            check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        sb_q.push_back(3'd3);
        sb_q.push_back(3'd6);
        bus.out_ready = 1'b1;
        tick();
        check("t3_code6", 32'(bus.out_code), 32'd6);
        tick();
        check("t3_idle", 32'(bus.out_valid), 32'd0);

        // Overflow: a second rise on an already-pending bit merges and pulses ovf.
        bus.out_ready = 1'b0;
        bus.req = 8'h02;
        tick();
        bus.req = 8'h00;
        tick();
        bus.req = 8'h10;
        tick();
        check("t4_ovf_first", 32'(bus.ovf), 32'd0);
        bus.req = 8'h00;
        tick();
        bus.req = 8'h10;
        tick();
        check("t4_ovf", 32'(bus.ovf), 32'd1);
        check("t4_pending", 32'(bus.pending), 32'h10);
        tick();
        check("t4_ovf_clear", 32'(bus.ovf), 32'd0);
        bus.req = 8'h00;
        sb_q.push_back(3'd1);
        sb_q.push_back(3'd4);
        bus.out_ready = 1'b1;
        tick();
        check("t4_code4", 32'(bus.out_code), 32'd4);
        tick();
        check("t4_idle", {23'd0, bus.out_valid, bus.pending}, 32'd0);

        // Rise on bit 2 in the very cycle bit 2 is claimed.
        bus.out_ready = 1'b0;
        bus.req = 8'h02;
        tick();
        bus.req = 8'h00;
        tick();
        bus.req = 8'h04;
        tick();
        bus.req = 8'h00;
        tick();
        push3(3'd1, 3'd2, 3'd2);
        bus.out_ready = 1'b1;
        bus.req = 8'h04;
        tick();
        check("t5_code", 32'(bus.out_code), 32'd2);
        check("t5_pending", 32'(bus.pending), 32'h04);
        check("t5_ovf", 32'(bus.ovf), 32'd0);
        bus.req = 8'h00;
        tick();
        check("t5_code_again", 32'(bus.out_code), 32'd2);
        check("t5_pend_clear", 32'(bus.pending), 32'd0);
        tick();
        check("t5_idle", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset while a code is held and another is pending.
        bus.out_ready = 1'b0;
        bus.req = 8'h18;
        tick();
        bus.req = 8'h00;
        tick();
        check("ar_valid_before", 32'(bus.out_valid), 32'd1);
        check("ar_pend_before", 32'(bus.pending), 32'h08);
        #2;
        CR = 1'b0;
        #1;
        check("ar_valid", 32'(bus.out_valid), 32'd0);
        check("ar_pending", 32'(bus.pending), 32'd0);
        check("ar_code", 32'(bus.out_code), 32'd0);

        // Two simultaneous requests held from reset; order depends on priority mode.
        bus.req = 8'h81;
        bus.out_ready = 1'b1;
        tick();
        CR = 1'b1;
        tick();
        check("t6_pending", 32'(bus.pending), 32'h81);
`ifdef ROUND_ROBIN_EN
        sb_q.push_back(3'd0);
        sb_q.push_back(3'd7);
`else
        sb_q.push_back(3'd7);
        sb_q.push_back(3'd0);
`endif
        wait_idle("t6_drain1");
        bus.req = 8'h00;
        tick();
        bus.req = 8'h81;
`ifdef ROUND_ROBIN_EN
        sb_q.push_back(3'd0);
        sb_q.push_back(3'd7);
`else
        sb_q.push_back(3'd7);
        sb_q.push_back(3'd0);
`endif
        tick();
        check("t6_pending2", 32'(bus.pending), 32'h81);
        wait_idle("t6_drain2");
        bus.req = 8'h00;
        tick();

        check("sb_left", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
